// File: rtl/arith_div_issue.sv
// arith_div_issue: single-slot issue stage in front of an iterative divider and
// an arithmetic DSP unit. Accepts one operation, latches its operands, pulses
// the start of the selected unit, waits for it (bounded by TIMEOUT) and
// holds the result in a one-entry output buffer until it is consumed.
// Divide-by-zero is resolved locally without starting the divider.
module arith_div_issue #(
   parameter int unsigned TIMEOUT = 64
) (
   input  logic        clk_i,
   input  logic        rst_ni,

   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic        req_unit_i,
   input  logic [4:0]  req_op_i,
   input  logic [31:0] A_i,
   input  logic [31:0] B_i,
   input  logic [31:0] C_i,
   input  logic [31:0] D_i,

   output logic        div_start_o,
   output logic        arith_start_o,
   output logic [4:0]  op_o,
   output logic [31:0] opA_o,
   output logic [31:0] opB_o,
   output logic [31:0] opC_o,
   output logic [31:0] opD_o,

   input  logic        div_ready_i,
   input  logic [31:0] div_q_i,
   input  logic [31:0] div_r_i,
   input  logic        arith_ready_i,
   input  logic [63:0] arith_result_i,

   output logic        res_valid_o,
   input  logic        res_ready_i,
   output logic [31:0] res_lo_o,
   output logic [31:0] res_hi_o,
   output logic [1:0]  res_flags_o
);

   // Counter wide enough to hold TIMEOUT itself; guard the degenerate case.
   localparam int unsigned     CNT_W   = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

   localparam logic [1:0] FLAG_NONE    = 2'b00;
   localparam logic [1:0] FLAG_DIV0    = 2'b01;
   localparam logic [1:0] FLAG_TIMEOUT = 2'b10;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT
   } state_t;

   state_t           state_q;
   logic             unit_q;      // unit of the op in flight: 0=divider, 1=arith
   logic [CNT_W-1:0] wait_cnt_q;  // WAIT cycles elapsed, first WAIT cycle is 1

   logic        accept;
   logic        sel_ready;
   logic [31:0] sel_lo;
   logic [31:0] sel_hi;

   // A new op may enter only from IDLE, and only if the result buffer is free
   // now or is being emptied in this same cycle.
   assign req_ready_o = (state_q == IDLE) & (~res_valid_o | res_ready_i);
   assign accept      = req_valid_i & req_ready_o;

   // Only the unit that was started is observed; the other one is ignored.
   assign sel_ready = unit_q ? arith_ready_i         : div_ready_i;
   assign sel_lo    = unit_q ? arith_result_i[31:0]  : div_q_i;
   assign sel_hi    = unit_q ? arith_result_i[63:32] : div_r_i;

   // Issue FSM, operand latches, start pulses and result buffer.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q       <= IDLE;
         unit_q        <= 1'b0;
         wait_cnt_q    <= '0;
         div_start_o   <= 1'b0;
         arith_start_o <= 1'b0;
         op_o          <= '0;
         opA_o         <= '0;
         opB_o         <= '0;
         opC_o         <= '0;
         opD_o         <= '0;
         res_valid_o   <= 1'b0;
         res_lo_o      <= '0;
         res_hi_o      <= '0;
         res_flags_o   <= '0;
      end else begin
         // NOTE: non-blocking assignments throughout, so every branch below
         // sees the pre-edge register values and later assignments in this
         // block simply override the defaults set here.
         div_start_o   <= 1'b0;
         arith_start_o <= 1'b0;

         // Consumption empties the buffer unless a new result lands below.
         if (res_valid_o && res_ready_i) begin
            res_valid_o <= 1'b0;
         end

         case (state_q)
            IDLE: begin
               if (accept) begin
                  op_o   <= req_op_i;
                  opA_o  <= A_i;
                  opB_o  <= B_i;
                  opC_o  <= C_i;
                  opD_o  <= D_i;
                  unit_q <= req_unit_i;
                  if (!req_unit_i && (B_i == '0)) begin
                     // Divide-by-zero answered immediately; divider untouched.
                     res_valid_o <= 1'b1;
                     res_lo_o    <= '1;
                     res_hi_o    <= A_i;
                     res_flags_o <= FLAG_DIV0;
                  end else begin
                     state_q       <= ISSUE;
                     div_start_o   <= ~req_unit_i;
                     arith_start_o <= req_unit_i;
                  end
               end
            end

            ISSUE: begin
               // Unit ready is stale here (it drops one cycle after start).
               state_q    <= WAIT;
               wait_cnt_q <= CNT_W'(1);
            end

            WAIT: begin
               if (sel_ready) begin
                  state_q     <= IDLE;
                  wait_cnt_q  <= '0;
                  res_valid_o <= 1'b1;
                  res_lo_o    <= sel_lo;
                  res_hi_o    <= sel_hi;
                  res_flags_o <= FLAG_NONE;
               end else if (wait_cnt_q == CNT_MAX) begin
                  state_q     <= IDLE;
                  wait_cnt_q  <= '0;
                  res_valid_o <= 1'b1;
                  res_lo_o    <= '0;
                  res_hi_o    <= '0;
                  res_flags_o <= FLAG_TIMEOUT;
               end else begin
                  wait_cnt_q <= wait_cnt_q + CNT_W'(1);
               end
            end

            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_arith_div_issue.sv
// Self-checking bench for arith_div_issue: directed ops against small divider
// and arith unit models, with a scoreboard queue checked by a monitor process.
module tb_arith_div_issue;

   localparam int unsigned TIMEOUT   = 64;
   localparam int          DIV_LAT   = 32;
   localparam int          ARITH_LAT = 5;

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic        req_valid_i;
   logic        req_ready_o;
   logic        req_unit_i;
   logic [4:0]  req_op_i;
   logic [31:0] A_i, B_i, C_i, D_i;
   logic        div_start_o, arith_start_o;
   logic [4:0]  op_o;
   logic [31:0] opA_o, opB_o, opC_o, opD_o;
   logic        div_ready_i;
   logic [31:0] div_q_i, div_r_i;
   logic        arith_ready_i;
   logic [63:0] arith_result_i;
   logic        res_valid_o;
   logic        res_ready_i;
   logic [31:0] res_lo_o, res_hi_o;
   logic [1:0]  res_flags_o;

   arith_div_issue #(.TIMEOUT(TIMEOUT)) dut (
      .clk_i          (clk_i),
      .rst_ni         (rst_ni),
      .req_valid_i    (req_valid_i),
      .req_ready_o    (req_ready_o),
      .req_unit_i     (req_unit_i),
      .req_op_i       (req_op_i),
      .A_i            (A_i),
      .B_i            (B_i),
      .C_i            (C_i),
      .D_i            (D_i),
      .div_start_o    (div_start_o),
      .arith_start_o  (arith_start_o),
      .op_o           (op_o),
      .opA_o          (opA_o),
      .opB_o          (opB_o),
      .opC_o          (opC_o),
      .opD_o          (opD_o),
      .div_ready_i    (div_ready_i),
      .div_q_i        (div_q_i),
      .div_r_i        (div_r_i),
      .arith_ready_i  (arith_ready_i),
      .arith_result_i (arith_result_i),
      .res_valid_o    (res_valid_o),
      .res_ready_i    (res_ready_i),
      .res_lo_o       (res_lo_o),
      .res_hi_o       (res_hi_o),
      .res_flags_o    (res_flags_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct packed {
      logic [31:0] lo;
      logic [31:0] hi;
      logic [1:0]  flags;
   } res_t;

   res_t exp_q[$];
   res_t mon_e;
   int   n_cmp = 0;
   int   n_err = 0;
   int   div_pulses = 0;
   int   arith_pulses = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Divider model: ready drops the cycle after start, result after DIV_LAT.
   logic        div_never = 1'b0;
   int          div_cnt;
   logic [31:0] div_a, div_b;
   always @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         div_ready_i <= 1'b1;
         div_cnt     <= 0;
         div_q_i     <= 32'h5A5A_5A5A;
         div_r_i     <= 32'hA5A5_A5A5;
         div_a       <= '0;
         div_b       <= '0;
      end else if (div_start_o) begin
         div_ready_i <= 1'b0;
         div_cnt     <= DIV_LAT;
         div_q_i     <= 32'hDEAD_BEEF;
         div_r_i     <= 32'hDEAD_BEEF;
         div_a       <= opA_o;
         div_b       <= opB_o;
      end else if (div_cnt == 1 && !div_never) begin
         div_ready_i <= 1'b1;
         div_cnt     <= 0;
         div_q_i     <= div_a / div_b;
         div_r_i     <= div_a % div_b;
      end else if (div_cnt > 1) begin
         div_cnt <= div_cnt - 1;
      end
   end

   // Arith model: returns arith_model_res ARITH_LAT cycles after start.
   logic [63:0] arith_model_res = '0;
   int          arith_cnt;
   always @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         arith_ready_i  <= 1'b1;
         arith_cnt      <= 0;
         arith_result_i <= 64'hC3C3_C3C3_C3C3_C3C3;
      end else if (arith_start_o) begin
         arith_ready_i  <= 1'b0;
         arith_cnt      <= ARITH_LAT;
         arith_result_i <= 64'hBAD0_BAD0_BAD0_BAD0;
      end else if (arith_cnt == 1) begin
         arith_ready_i  <= 1'b1;
         arith_cnt      <= 0;
         arith_result_i <= arith_model_res;
      end else if (arith_cnt > 1) begin
         arith_cnt <= arith_cnt - 1;
      end
   end

   // Count start pulses (cycles with a start output high).
   always @(negedge clk_i) begin
      if (div_start_o)   div_pulses++;
      if (arith_start_o) arith_pulses++;
   end

   // Monitor: every consumed result is compared against the scoreboard head.
   always @(negedge clk_i) begin
      if (rst_ni && res_valid_o && res_ready_i) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_result: got lo=%h hi=%h flags=%b expected none",
                     res_lo_o, res_hi_o, res_flags_o);
         end else begin
            mon_e = exp_q.pop_front();
            check("res_lo",    64'(res_lo_o),    64'(mon_e.lo));
            check("res_hi",    64'(res_hi_o),    64'(mon_e.hi));
            check("res_flags", 64'(res_flags_o), 64'(mon_e.flags));
         end
      end
   end

   // Offer one op; returns 1 time unit after the accepting edge.
   task automatic issue(input logic unit, input logic [4:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] c, input logic [31:0] d,
                        input logic rel_res);
      int n = 0;
      @(posedge clk_i);
      #1;
      req_valid_i = 1'b1;
      req_unit_i  = unit;
      req_op_i    = op;
      A_i = a; B_i = b; C_i = c; D_i = d;
      if (rel_res) res_ready_i = 1'b1;
      @(negedge clk_i);
      while (!req_ready_o && n < 200) begin
         @(negedge clk_i);
         n++;
      end
      if (!req_ready_o) begin
         n_cmp++;
         n_err++;
         $display("FAIL accept_timeout: req_ready_o stayed %b, expected 1", req_ready_o);
      end
      @(posedge clk_i);
      #1;
      req_valid_i = 1'b0;
      req_unit_i  = 1'($urandom);
      req_op_i    = 5'($urandom);
      A_i = $urandom; B_i = $urandom; C_i = $urandom; D_i = $urandom;
   endtask

   task automatic drain(input int budget);
      int n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         @(negedge clk_i);
         n++;
      end
      #1;
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_err++;
         $display("FAIL drain: %0d results pending after %0d cycles, expected 0", exp_q.size(), n);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_res_valid"},   64'(res_valid_o),   64'd0);
      check({tag, "_div_start"},   64'(div_start_o),   64'd0);
      check({tag, "_arith_start"}, 64'(arith_start_o), 64'd0);
      check({tag, "_op"},          64'(op_o),          64'd0);
      check({tag, "_opA"},         64'(opA_o),         64'd0);
      check({tag, "_opB"},         64'(opB_o),         64'd0);
      check({tag, "_opC"},         64'(opC_o),         64'd0);
      check({tag, "_opD"},         64'(opD_o),         64'd0);
      check({tag, "_res_lo"},      64'(res_lo_o),      64'd0);
      check({tag, "_res_hi"},      64'(res_hi_o),      64'd0);
      check({tag, "_flags"},       64'(res_flags_o),   64'd0);
   endtask

   int div_snap, arith_snap, n;

   initial begin
      rst_ni      = 1'b0;
      req_valid_i = 1'b0;
      req_unit_i  = 1'b0;
      req_op_i    = '0;
      A_i = '0; B_i = '0; C_i = '0; D_i = '0;
      res_ready_i = 1'b1;

      // Reset state and first cycle after release.
      repeat (3) @(negedge clk_i);
      check_all_zero("reset");
      rst_ni = 1'b1;
      @(negedge clk_i);
      check("post_reset_req_ready", 64'(req_ready_o), 64'd1);

      // Divider 100 / 7 with operand latching.
      div_snap = div_pulses; arith_snap = arith_pulses;
      exp_q.push_back('{lo: 32'd14, hi: 32'd2, flags: 2'b00});
      issue(1'b0, 5'd9, 32'd100, 32'd7, 32'h0000_CCCC, 32'h0000_DDDD, 1'b0);
      @(negedge clk_i);
      check("latch_op",  64'(op_o),  64'd9);
      check("latch_opA", 64'(opA_o), 64'd100);
      check("latch_opB", 64'(opB_o), 64'd7);
      check("latch_opC", 64'(opC_o), 64'h0000_CCCC);
      check("latch_opD", 64'(opD_o), 64'h0000_DDDD);
      drain(200);
      check("div_start_pulses", 64'(div_pulses - div_snap), 64'd1);
      check("div_arith_pulses", 64'(arith_pulses - arith_snap), 64'd0);
      check("latch_opA_held", 64'(opA_o), 64'd100);

      // Divide-by-zero: no divider start, result on the next cycle.
      div_snap = div_pulses;
      exp_q.push_back('{lo: 32'hFFFF_FFFF, hi: 32'd5, flags: 2'b01});
      issue(1'b0, 5'd1, 32'd5, 32'd0, 32'd0, 32'd0, 1'b0);
      @(negedge clk_i);
      check("div0_next_cycle_valid", 64'(res_valid_o), 64'd1);
      drain(20);
      check("div0_no_start", 64'(div_pulses - div_snap), 64'd0);

      // Arith op with B=0 is not a divide-by-zero.
      div_snap = div_pulses; arith_snap = arith_pulses;
      arith_model_res = 64'hFFFF_FFFF_FFFF_FFF6;
      exp_q.push_back('{lo: 32'hFFFF_FFF6, hi: 32'hFFFF_FFFF, flags: 2'b00});
      issue(1'b1, 5'd3, 32'd2, 32'd0, 32'd0, 32'd0, 1'b0);
      drain(50);
      check("arith_start_pulses", 64'(arith_pulses - arith_snap), 64'd1);
      check("arith_div_pulses",   64'(div_pulses - div_snap), 64'd0);

      // Result held under backpressure, then consume + accept in one cycle.
      @(posedge clk_i);
      #1;
      res_ready_i     = 1'b0;
      arith_model_res = 64'h0000_0001_8000_0000;
      exp_q.push_back('{lo: 32'h8000_0000, hi: 32'h0000_0001, flags: 2'b00});
      issue(1'b1, 5'd4, 32'd1, 32'd2, 32'd3, 32'd4, 1'b0);
      n = 0;
      @(negedge clk_i);
      while (!res_valid_o && n < 50) begin
         @(negedge clk_i);
         n++;
      end
      for (int i = 0; i < 10; i++) begin
         check("stall_res_valid", 64'(res_valid_o), 64'd1);
         check("stall_req_ready", 64'(req_ready_o), 64'd0);
         check("stall_res_lo",    64'(res_lo_o),    64'h8000_0000);
         @(negedge clk_i);
      end
      exp_q.push_back('{lo: 32'hFFFF_FFFF, hi: 32'h0000_1234, flags: 2'b01});
      issue(1'b0, 5'd2, 32'h0000_1234, 32'd0, 32'd0, 32'd0, 1'b1);
      @(negedge clk_i);
      check("b2b_res_valid_kept", 64'(res_valid_o), 64'd1);
      check("b2b_res_hi",         64'(res_hi_o),    64'h0000_1234);
      drain(20);

      // Divider never answers: timeout after TIMEOUT WAIT cycles.
      div_never = 1'b1;
      exp_q.push_back('{lo: 32'd0, hi: 32'd0, flags: 2'b10});
      issue(1'b0, 5'd5, 32'd8, 32'd2, 32'd0, 32'd0, 1'b0);
      n = 0;
      while (n < 200) begin
         @(posedge clk_i);
         n++;
         @(negedge clk_i);
         if (res_valid_o) break;
      end
      check("timeout_latency", 64'(n), 64'(TIMEOUT + 1));
      drain(20);

      // Asynchronous reset in the middle of WAIT; op dropped silently.
      issue(1'b0, 5'd6, 32'd1, 32'd1, 32'd7, 32'd7, 1'b0);
      repeat (10) @(negedge clk_i);
      #2;
      rst_ni = 1'b0;
      #1;
      check_all_zero("async_reset");
      div_never = 1'b0;
      @(negedge clk_i);
      rst_ni = 1'b1;
      @(negedge clk_i);
      check("rerelease_req_ready", 64'(req_ready_o), 64'd1);
      check("rerelease_no_start",  64'(div_start_o), 64'd0);

      exp_q.push_back('{lo: 32'd3, hi: 32'd0, flags: 2'b00});
      issue(1'b0, 5'd7, 32'd9, 32'd3, 32'd0, 32'd0, 1'b0);
      drain(200);

      repeat (5) @(negedge clk_i);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   // Global safety net so the run always ends.
   initial begin
      #500000;
      $display("FAIL global_timeout: simulation still running, expected finish");
      $fatal(1, "global timeout");
   end

endmodule
